matriz_varredura: RTL and testbench



---
 rtl/matriz_varredura.sv | 125 ++++++++++++
 tb/tb_matriz_varredura.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/matriz_varredura.sv
// Column-scan driver for the 5x7 LED matrix of the elevator display.
// Double-buffered image swap at frame boundaries, anti-ghost blank cycle per column, optional blink.
module matriz_varredura #(
    parameter int DIV_COLUNA    = 50000,
    parameter int QUADROS_PISCA = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [34:0] imagem,
    input  logic        carregar,
    input  logic        piscar,
    output logic [4:0]  colunas,
    output logic [6:0]  linhas,
    output logic        quadro_fim
);

    localparam int PW = (DIV_COLUNA > 1) ? $clog2(DIV_COLUNA) : 1;
    localparam int FW = $clog2(QUADROS_PISCA + 1);

    localparam logic [PW-1:0] PRE_ULTIMO  = PW'(DIV_COLUNA - 1);
    localparam logic [FW-1:0] QUADRO_ULT  = FW'(QUADROS_PISCA - 1);
    localparam logic [2:0]    COL_ULTIMA  = 3'd4;

    logic [PW-1:0] pre, pre_n;
    logic [2:0]    col, col_n;
    logic [FW-1:0] cont, cont_n;
    logic [34:0]   ativa, ativa_n;
    logic [34:0]   sombra, sombra_n;
    logic          pendente, pendente_n;
    logic          visivel, visivel_n;
    logic          fronteira;
    logic [4:0]    colunas_n;
    logic [6:0]    linhas_n;
    logic [6:0]    fatia;

    // Outputs are registered from next-state values so each output cycle
    // reflects the prescaler/column position of that same cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        pre_n      = pre;
        col_n      = col;
        cont_n     = cont;
        ativa_n    = ativa;
        sombra_n   = sombra;
        pendente_n = pendente;
        visivel_n  = visivel;
        colunas_n  = '0;
        linhas_n   = 7'h7F;
        fatia      = '0;

        fronteira = (pre == PRE_ULTIMO) && (col == COL_ULTIMA);

        if (pre == PRE_ULTIMO) begin
            pre_n = '0;
            col_n = (col == COL_ULTIMA) ? 3'd0 : col + 3'd1;
        end else begin
            pre_n = pre + PW'(1);
        end

        // A strobe on the boundary itself bypasses the shadow so it lands without a frame of delay.
        if (fronteira && carregar) begin
            ativa_n    = imagem;
            sombra_n   = imagem;
            pendente_n = 1'b0;
        end else if (carregar) begin
            sombra_n   = imagem;
            pendente_n = 1'b1;
        end else if (fronteira && pendente) begin
            ativa_n    = sombra;
            pendente_n = 1'b0;
        end

        if (!piscar) begin
            cont_n    = '0;
            visivel_n = 1'b1;
        end else if (fronteira) begin
            if (cont == QUADRO_ULT) begin
                cont_n    = '0;
                visivel_n = ~visivel;
            end else begin
                cont_n = cont + FW'(1);
            end
        end

        if (pre_n != '0) begin
            case (col_n)
                3'd0: begin colunas_n = 5'b00001; fatia = ativa_n[6:0];   end
                3'd1: begin colunas_n = 5'b00010; fatia = ativa_n[13:7];  end
                3'd2: begin colunas_n = 5'b00100; fatia = ativa_n[20:14]; end
                3'd3: begin colunas_n = 5'b01000; fatia = ativa_n[27:21]; end
                3'd4: begin colunas_n = 5'b10000; fatia = ativa_n[34:28]; end
                default: begin colunas_n = 5'b00000; fatia = 7'h00; end
            endcase
            linhas_n = ~(fatia & {7{visivel_n}});
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            pre        <= '0;
            col        <= '0;
            cont       <= '0;
            ativa      <= '0;
            sombra     <= '0;
            pendente   <= 1'b0;
            visivel    <= 1'b1;
            colunas    <= 5'b00000;
            linhas     <= 7'h7F;
            quadro_fim <= 1'b0;
        end else begin
            pre        <= pre_n;
            col        <= col_n;
            cont       <= cont_n;
            ativa      <= ativa_n;
            sombra     <= sombra_n;
            pendente   <= pendente_n;
            visivel    <= visivel_n;
            colunas    <= colunas_n;
            linhas     <= linhas_n;
            quadro_fim <= fronteira;
        end
    end

endmodule

// File: tb/tb_matriz_varredura.sv
// Self-checking bench for matriz_varredura: per-cycle expected outputs are queued
// from a frame model as stimulus is driven, then popped and compared each cycle.
module tb_matriz_varredura;

    localparam int DIV    = 4;
    localparam int QP     = 2;
    localparam int QUADRO = 5 * DIV;

    localparam logic [34:0] SETA_CIMA  = {7'h04, 7'h06, 7'h7F, 7'h06, 7'h04};
    localparam logic [34:0] SETA_BAIXO = {7'h10, 7'h30, 7'h7F, 7'h30, 7'h10};
    localparam logic [34:0] XADREZ     = {7'h55, 7'h2A, 7'h55, 7'h2A, 7'h55};
    localparam logic [34:0] VAZIA      = 35'd0;

    logic        clk = 1'b0;
    logic        reset;
    logic [34:0] imagem;
    logic        carregar;
    logic        piscar;
    logic [4:0]  colunas;
    logic [6:0]  linhas;
    logic        quadro_fim;

    typedef struct packed {
        logic [4:0] c;
        logic [6:0] l;
        logic       q;
    } saida_t;

    saida_t esperado[$];
    int erros  = 0;
    int checks = 0;

    always #5 clk = ~clk;

    matriz_varredura #(
        .DIV_COLUNA   (DIV),
        .QUADROS_PISCA(QP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .imagem    (imagem),
        .carregar  (carregar),
        .piscar    (piscar),
        .colunas   (colunas),
        .linhas    (linhas),
        .quadro_fim(quadro_fim)
    );

    function automatic saida_t modelo(input logic [34:0] img, input int j, input logic vis, input logic q);
        saida_t      s;
        logic [34:0] sh;
        int          k;
        int          p;
        k   = j / DIV;
        p   = j % DIV;
        s.q = q;
        if (p == 0) begin
            s.c = 5'b00000;
            s.l = 7'h7F;
        end else begin
            s.c = 5'(1 << k);
            sh  = img >> (7 * k);
            s.l = ~(sh[6:0] & {7{vis}});
        end
        return s;
    endfunction

    // Starts at the falling edge of frame cycle 0 and ends at frame cycle n.
    task automatic varrer_quadro(input string nome, input logic [34:0] img, input int vis_desde,
                                 input logic qf0, input int n,
                                 input int carga_a, input logic [34:0] img_a,
                                 input int carga_b, input logic [34:0] img_b,
                                 input int solta_pisca);
        saida_t esp;
        saida_t obs;
        for (int j = 0; j < n; j++)
            esperado.push_back(modelo(img, j, j >= vis_desde, (j == 0) ? qf0 : 1'b0));
        for (int j = 0; j < n; j++) begin
            carregar = 1'b0;
            if (j == carga_a) begin imagem = img_a; carregar = 1'b1; end
            if (j == carga_b) begin imagem = img_b; carregar = 1'b1; end
            if (j == solta_pisca) piscar = 1'b0;
            esp = esperado.pop_front();
            obs = {colunas, linhas, quadro_fim};
            checks++;
            if (obs !== esp) begin
                erros++;
                $display("FAIL %s cycle %0d: got colunas=%b linhas=%b quadro_fim=%b, want colunas=%b linhas=%b quadro_fim=%b",
                         nome, j, obs.c, obs.l, obs.q, esp.c, esp.l, esp.q);
            end
            @(negedge clk);
        end
        carregar = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        carregar = 1'b0;
        piscar   = 1'b0;
        imagem   = VAZIA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({colunas, linhas, quadro_fim} !== {5'b00000, 7'h7F, 1'b0}) begin
                erros++;
                $display("FAIL reset_hold %0d: got colunas=%b linhas=%b quadro_fim=%b, want 00000 1111111 0",
                         i, colunas, linhas, quadro_fim);
            end
        end
        reset = 1'b0;
        varrer_quadro("reset_first_frame", VAZIA, 0, 1'b0, QUADRO, -1, VAZIA, -1, VAZIA, -1);
    endtask

    task automatic test_seta_cima();
        varrer_quadro("up_load_frame", VAZIA, 0, 1'b1, QUADRO, 5, SETA_CIMA, -1, VAZIA, -1);
        varrer_quadro("up_arrow", SETA_CIMA, 0, 1'b1, QUADRO, -1, VAZIA, -1, VAZIA, -1);
    endtask

    task automatic test_carga_meio();
        varrer_quadro("mid_load_old", SETA_CIMA, 0, 1'b1, QUADRO, 6, SETA_BAIXO, -1, VAZIA, -1);
        varrer_quadro("mid_load_new", SETA_BAIXO, 0, 1'b1, QUADRO, -1, VAZIA, -1, VAZIA, -1);
        varrer_quadro("override_old", SETA_BAIXO, 0, 1'b1, QUADRO, 3, SETA_CIMA, 12, XADREZ, -1);
        varrer_quadro("override_new", XADREZ, 0, 1'b1, QUADRO, -1, VAZIA, -1, VAZIA, -1);
    endtask

    task automatic test_carga_fronteira();
        varrer_quadro("boundary_old", XADREZ, 0, 1'b1, QUADRO, QUADRO - 1, SETA_CIMA, -1, VAZIA, -1);
        varrer_quadro("boundary_new", SETA_CIMA, 0, 1'b1, QUADRO, -1, VAZIA, -1, VAZIA, -1);
        varrer_quadro("boundary_hold", SETA_CIMA, 0, 1'b1, QUADRO, -1, VAZIA, -1, VAZIA, -1);
    endtask

    task automatic test_piscar();
        piscar = 1'b1;
        varrer_quadro("blink_f0", SETA_CIMA, 0, 1'b1, QUADRO, -1, VAZIA, -1, VAZIA, -1);
        varrer_quadro("blink_f1", SETA_CIMA, 0, 1'b1, QUADRO, -1, VAZIA, -1, VAZIA, -1);
        varrer_quadro("blink_f2", SETA_CIMA, QUADRO, 1'b1, QUADRO, -1, VAZIA, -1, VAZIA, -1);
        varrer_quadro("blink_f3", SETA_CIMA, QUADRO, 1'b1, QUADRO, -1, VAZIA, -1, VAZIA, -1);
        varrer_quadro("blink_f4", SETA_CIMA, 0, 1'b1, QUADRO, -1, VAZIA, -1, VAZIA, -1);
        varrer_quadro("blink_f5", SETA_CIMA, 0, 1'b1, QUADRO, -1, VAZIA, -1, VAZIA, -1);
        varrer_quadro("blink_drop", SETA_CIMA, 11, 1'b1, QUADRO, -1, VAZIA, -1, VAZIA, 10);
        varrer_quadro("blink_after", SETA_CIMA, 0, 1'b1, QUADRO, -1, VAZIA, -1, VAZIA, -1);
    endtask

    task automatic test_reset_meio();
        piscar = 1'b1;
        varrer_quadro("pre_reset", SETA_CIMA, 0, 1'b1, 13, -1, VAZIA, -1, VAZIA, -1);
        checks++;
        if ({colunas, linhas, quadro_fim} !== {5'b01000, 7'b1111001, 1'b0}) begin
            erros++;
            $display("FAIL col3_slot: got colunas=%b linhas=%b quadro_fim=%b, want 01000 1111001 0",
                     colunas, linhas, quadro_fim);
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({colunas, linhas, quadro_fim} !== {5'b00000, 7'h7F, 1'b0}) begin
                erros++;
                $display("FAIL mid_reset %0d: got colunas=%b linhas=%b quadro_fim=%b, want 00000 1111111 0",
                         i, colunas, linhas, quadro_fim);
            end
        end
        reset  = 1'b0;
        piscar = 1'b0;
        varrer_quadro("cleared_f0", VAZIA, 0, 1'b0, QUADRO, -1, VAZIA, -1, VAZIA, -1);
        varrer_quadro("cleared_f1", VAZIA, 0, 1'b1, QUADRO, 7, SETA_BAIXO, -1, VAZIA, -1);
        varrer_quadro("reloaded", SETA_BAIXO, 0, 1'b1, QUADRO, -1, VAZIA, -1, VAZIA, -1);
    endtask

    initial begin
        test_reset();
        test_seta_cima();
        test_carga_meio();
        test_carga_fronteira();
        test_piscar();
        test_reset_meio();
        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
